// File: rtl/digit_serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
// Holds the FSM state encoding and the digit-counter width function.
package digit_serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter must hold 0..n-1; a 1-bit counter is kept even when n==1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/digit_serial_adder_digit_add.sv
// Combinational DIGIT-bit ripple of full adders used once per RUN cycle.
// c_msb is the carry into the top bit, needed for signed overflow.
module digit_add #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout  = w_c[DIGIT];
    assign c_msb = w_c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands consumed DIGIT bits per
// clock through a registered carry, with valid/ready on both sides.
module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cnt_width(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    if (WIDTH < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $fatal(1, "digit_serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
    end

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic             r_cy;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic [WIDTH-1:0] w_res_next;
    logic [DIGIT-1:0] w_s;
    logic             w_cout;
    logic             w_cmsb;
    logic             w_accept;
    logic             w_run;
    logic             w_last;

    assign in_ready  = rst_n && (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_run     = (r_state == ST_RUN);
    assign w_last    = w_run && (r_cnt == LAST);

    assign sum       = r_sum;
    assign carry_out = r_cout;
    assign overflow  = r_ovf;

    digit_add #(.DIGIT(DIGIT)) u_digit_add (
        .a     (r_a_sr[DIGIT-1:0]),
        .b     (r_b_sr[DIGIT-1:0]),
        .cin   (r_cy),
        .s     (w_s),
        .cout  (w_cout),
        .c_msb (w_cmsb)
    );

    // Result digits enter from the MSB side; only the upper WIDTH-DIGIT bits
    // need storage since the newest digit comes straight from the adder.
    if (NDIG == 1) begin : g_single
        assign w_res_next = w_s;
    end else begin : g_multi
        logic [WIDTH-DIGIT-1:0] r_res;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_res <= '0;
            end else if (w_run) begin
                r_res <= w_res_next[WIDTH-1:DIGIT];
            end
        end

        assign w_res_next = {w_s, r_res};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_next = ST_RUN;
            ST_RUN:  if (w_last)    w_next = ST_DONE;
            ST_DONE: if (out_ready) w_next = ST_IDLE;
            default:                w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_a_sr <= '0;
            r_b_sr <= '0;
            r_cy   <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is A + ~B + 1: invert B and force the initial carry.
            r_a_sr <= a;
            r_b_sr <= sub ? ~b : b;
            r_cy   <= sub ? 1'b1 : carry_in;
            r_cnt  <= '0;
        end else if (w_run) begin
            r_a_sr <= r_a_sr >> DIGIT;
            r_b_sr <= r_b_sr >> DIGIT;
            r_cy   <= w_cout;
            r_cnt  <= r_cnt + CW'(1);
            if (w_last) begin
                r_sum  <= w_res_next;
                r_cout <= w_cout;
                r_ovf  <= w_cout ^ w_cmsb;
            end
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for digit_serial_adder at 8/2, plus 4/1 and 4/4 sweeps.
module tb_digit_serial_adder;

    typedef struct packed {
        logic [7:0] s;
        logic       co;
        logic       ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, sub, carry_in, out_valid, out_ready;
    logic [7:0] a, b, sum;
    logic       carry_out, overflow;

    logic       siv [2];
    logic       sir [2];
    logic [3:0] sa  [2];
    logic [3:0] sb  [2];
    logic       ssub[2];
    logic       scin[2];
    logic       sov [2];
    logic       sor [2];
    logic [3:0] ssum[2];
    logic       sco [2];
    logic       sovf[2];

    exp_t q[$];
    exp_t sq[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .carry_in(carry_in), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .carry_out(carry_out), .overflow(overflow)
    );

    digit_serial_adder #(.WIDTH(4), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(siv[0]), .in_ready(sir[0]),
        .a(sa[0]), .b(sb[0]), .sub(ssub[0]), .carry_in(scin[0]), .out_valid(sov[0]),
        .out_ready(sor[0]), .sum(ssum[0]), .carry_out(sco[0]), .overflow(sovf[0])
    );

    digit_serial_adder #(.WIDTH(4), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(siv[1]), .in_ready(sir[1]),
        .a(sa[1]), .b(sb[1]), .sub(ssub[1]), .carry_in(scin[1]), .out_valid(sov[1]),
        .out_ready(sor[1]), .sum(ssum[1]), .carry_out(sco[1]), .overflow(sovf[1])
    );

    function automatic exp_t ref_calc(input int w, input int av, input int bv,
                                      input int sbv, input int ci);
        int   mask;
        int   bb;
        int   t;
        int   sv;
        exp_t e;
        mask = (1 << w) - 1;
        bb   = sbv ? (~bv & mask) : (bv & mask);
        t    = (av & mask) + bb + (sbv ? 1 : (ci & 1));
        sv   = t & mask;
        e.s  = 8'(sv);
        e.co = 1'((t >> w) & 1);
        e.ov = ((((av >> (w-1)) & 1) == ((bb >> (w-1)) & 1)) &&
                (((sv >> (w-1)) & 1) != ((av >> (w-1)) & 1)));
        return e;
    endfunction

    task automatic send(input logic [7:0] av, input logic [7:0] bv,
                        input logic sbv, input logic ci);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_ready_timeout in_ready=%b required=1", in_ready);
        end
        a = av; b = bv; sub = sbv; carry_in = ci; in_valid = 1'b1;
        q.push_back(ref_calc(8, int'(av), int'(bv), int'(sbv), int'(ci)));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks += 5;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        if (sum !== 8'h00) begin failures++; $display("FAIL rst_sum got=%0d want=0", sum); end
        if (carry_out !== 1'b0) begin failures++; $display("FAIL rst_carry_out got=%b want=0", carry_out); end
        if (overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow got=%b want=0", overflow); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b want=1", in_ready); end
    endtask

    task automatic run_table(input string name, input logic [7:0] ta[3], input logic [7:0] tb[3],
                             input logic tsub[3], input logic tci[3], input logic [7:0] ts[3],
                             input logic tco[3], input logic tov[3], input int rows);
        int   lat;
        exp_t e;
        logic [7:0] held;
        for (int i = 0; i < rows; i++) begin
            send(ta[i], tb[i], tsub[i], tci[i]);
            wait_out(lat);
            e = q.pop_front();
            checks += 6;
            if (out_valid !== 1'b1 || lat != 4) begin
                failures++;
                $display("FAIL %s_latency row=%0d got=%0d want=4", name, i, lat);
            end
            if (sum !== ts[i]) begin failures++; $display("FAIL %s_sum row=%0d got=%0d want=%0d", name, i, sum, ts[i]); end
            if (carry_out !== tco[i]) begin failures++; $display("FAIL %s_cout row=%0d got=%b want=%b", name, i, carry_out, tco[i]); end
            if (overflow !== tov[i]) begin failures++; $display("FAIL %s_ovf row=%0d got=%b want=%b", name, i, overflow, tov[i]); end
            if ({sum, carry_out, overflow} !== e) begin
                failures++;
                $display("FAIL %s_model row=%0d got=%h want=%h", name, i, {sum, carry_out, overflow}, e);
            end
            held = sum;
            release_out();
            if (out_valid !== 1'b0 || sum !== held) begin
                failures++;
                $display("FAIL %s_after_done row=%0d out_valid=%b sum=%0d want 0/%0d", name, i, out_valid, sum, held);
            end
        end
    endtask

    task automatic test_add();
        logic [7:0] ta[3] = '{8'd200, 8'd100, 8'd255};
        logic [7:0] tb[3] = '{8'd100, 8'd100, 8'd0};
        logic tsub[3]     = '{1'b0, 1'b0, 1'b0};
        logic tci[3]      = '{1'b0, 1'b0, 1'b1};
        logic [7:0] ts[3] = '{8'd44, 8'd200, 8'd0};
        logic tco[3]      = '{1'b1, 1'b0, 1'b1};
        logic tov[3]      = '{1'b0, 1'b1, 1'b0};
        run_table("add", ta, tb, tsub, tci, ts, tco, tov, 3);
    endtask

    task automatic test_sub();
        logic [7:0] ta[3] = '{8'd5, 8'd128, 8'd0};
        logic [7:0] tb[3] = '{8'd7, 8'd1, 8'd0};
        logic tsub[3]     = '{1'b1, 1'b1, 1'b1};
        logic tci[3]      = '{1'b1, 1'b0, 1'b1};
        logic [7:0] ts[3] = '{8'd254, 8'd127, 8'd0};
        logic tco[3]      = '{1'b0, 1'b1, 1'b1};
        logic tov[3]      = '{1'b0, 1'b1, 1'b0};
        run_table("sub", ta, tb, tsub, tci, ts, tco, tov, 3);
    endtask

    task automatic test_backpressure();
        int   lat;
        exp_t e;
        send(8'd90, 8'd80, 1'b0, 1'b1);
        wait_out(lat);
        e = q.pop_front();
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a = 8'(i * 17); b = 8'(i * 3); sub = i[1];
            @(negedge clk);
            checks += 3;
            if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid cyc=%0d got=%b want=1", i, out_valid); end
            if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", i, in_ready); end
            if ({sum, carry_out, overflow} !== e) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got=%h want=%h", i, {sum, carry_out, overflow}, e);
            end
        end
        in_valid = 1'b0;
        release_out();
        checks += 2;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b want=0", out_valid); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
        send(8'd3, 8'd4, 1'b0, 1'b0);
        wait_out(lat);
        e = q.pop_front();
        checks += 2;
        if (lat != 4) begin failures++; $display("FAIL bp_next_latency got=%0d want=4", lat); end
        if ({sum, carry_out, overflow} !== e) begin
            failures++;
            $display("FAIL bp_next_result got=%h want=%h", {sum, carry_out, overflow}, e);
        end
        release_out();
    endtask

    task automatic test_reset_mid();
        int   lat;
        exp_t e;
        send(8'd60, 8'd70, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks += 5;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_out_valid got=%b want=0", out_valid); end
        if (sum !== 8'h00) begin failures++; $display("FAIL rmid_sum got=%0d want=0", sum); end
        if (carry_out !== 1'b0) begin failures++; $display("FAIL rmid_carry_out got=%b want=0", carry_out); end
        if (overflow !== 1'b0) begin failures++; $display("FAIL rmid_overflow got=%b want=0", overflow); end
        if (in_ready !== 1'b0) begin failures++; $display("FAIL rmid_in_ready got=%b want=0", in_ready); end
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_no_partial cyc=%0d got=%b want=0", i, out_valid); end
        end
        send(8'd1, 8'd1, 1'b0, 1'b0);
        wait_out(lat);
        e = q.pop_front();
        checks += 2;
        if (sum !== 8'd2) begin failures++; $display("FAIL rmid_fresh_sum got=%0d want=2", sum); end
        if ({sum, carry_out, overflow} !== e) begin
            failures++;
            $display("FAIL rmid_fresh_model got=%h want=%h", {sum, carry_out, overflow}, e);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        int   lat;
        exp_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_out(lat);
            e = q.pop_front();
            checks += 2;
            if (lat != 4) begin failures++; $display("FAIL b2b_latency op=%0d got=%0d want=4", i, lat); end
            if ({sum, carry_out, overflow} !== e) begin
                failures++;
                $display("FAIL b2b_result op=%0d got=%h want=%h", i, {sum, carry_out, overflow}, e);
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_sweep(input int k);
        int   n;
        bit   done;
        exp_t e;
        for (int av = 0; av < 16; av++)
        for (int bv = 0; bv < 16; bv++)
        for (int sbv = 0; sbv < 2; sbv++)
        for (int ci = 0; ci < 2; ci++) begin
            n = 0;
            while (!sir[k] && n < 20) begin @(negedge clk); n++; end
            sa[k] = 4'(av); sb[k] = 4'(bv); ssub[k] = 1'(sbv); scin[k] = 1'(ci);
            siv[k] = 1'b1;
            sq.push_back(ref_calc(4, av, bv, sbv, ci));
            @(negedge clk);
            siv[k] = 1'b0;
            n = 0;
            done = 1'b0;
            while (!done && n < 100) begin
                sor[k] = 1'($urandom_range(0, 1));
                if (sov[k] && sor[k]) begin
                    e = sq.pop_front();
                    checks++;
                    if ({ssum[k], sco[k], sovf[k]} !== {e.s[3:0], e.co, e.ov}) begin
                        failures++;
                        $display("FAIL sweep%0d a=%0d b=%0d sub=%0d cin=%0d got=%h want=%h",
                                 k, av, bv, sbv, ci, {ssum[k], sco[k], sovf[k]}, {e.s[3:0], e.co, e.ov});
                    end
                    done = 1'b1;
                end
                @(negedge clk);
                n++;
            end
            sor[k] = 1'b0;
            if (!done) begin
                checks++;
                failures++;
                $display("FAIL sweep%0d_timeout a=%0d b=%0d out_valid=%b want=1", k, av, bv, sov[k]);
                sq.delete();
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0; carry_in = 1'b0;
        for (int k = 0; k < 2; k++) begin
            siv[k] = 1'b0; sor[k] = 1'b0; sa[k] = '0; sb[k] = '0; ssub[k] = 1'b0; scin[k] = 1'b0;
        end
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_sweep(0);
        test_sweep(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
